alu8_sequencer: RTL and testbench
=================================

# alu8_sequencer

Controller that performs 8-bit add, subtract and clear operations by sequencing the existing 4-bit registered add/subtract unit over two nibble passes. The low nibble runs first, and its carry/borrow is chained through RCO→RCI into the high-nibble pass. The block sits between a single requester (START/DONE handshake) and the 4-bit unit, driving all of the unit's control and operand inputs.

## Interface
Parameters:
- None. Widths are fixed: 8-bit operands, 4-bit unit.

Ports:
- CLK  in  1  rising-edge clock, shared with the 4-bit unit
- RST  in  1  reset, synchronous, active-high
- START  in  1  request; sampled only in IDLE
- OP  in  2  operation: 01 add, 10 subtract, 11 clear; 00 is illegal and ignored
- A8  in  8  operand A
- B8  in  8  operand B
- CIN  in  1  carry-in (add) or borrow-in (subtract)
- BUSY  out  1  high from acceptance through the FIN state
- DONE  out  1  one-cycle pulse; R8/COUT valid from this cycle on
- R8  out  8  result register
- COUT  out  1  final carry (add) or borrow (subtract)
- A  out  4  operand nibble to unit
- B  out  4  operand nibble to unit
- MODO  out  2  unit mode
- ENB  out  1  unit enable
- RCI  out  1  unit carry/borrow in
- Q  in  4  unit result
- RCO  in  1  unit carry/borrow out

## Operation
- Unit contract relied on: at each CLK edge with ENB=1, the unit updates as follows. MODO 01: Q,RCO ← A+B+RCI. MODO 10: Q ← A−B−RCI, RCO = borrow. MODO 11: Q,RCO ← 0. MODO 00: hold. ENB=0 always holds.
- FSM states: IDLE, LO, HI, FIN.
- IDLE: MODO=00, ENB=0, A=B=0, RCI=0.
  - START=1 with OP≠00: latch A8, B8, CIN, OP; go to LO.
  - Otherwise stay in IDLE.
- LO: A=A8[3:0], B=B8[3:0], MODO=OP, RCI=CIN, ENB=1 → HI.
- HI: A=A8[7:4], B=B8[7:4], MODO=OP, RCI=RCO (live carry from the low pass), ENB=1. At the exit edge, R8[3:0] ← Q → FIN.
- FIN: ENB=0. At the exit edge, R8[7:4] ← Q, COUT ← RCO, DONE ← 1 → IDLE.
- Clear (OP=11) runs both passes; result R8=0x00, COUT=0.
- Arithmetic is modulo 256. For add, COUT = bit 8 of A8+B8+CIN. For subtract, COUT=1 when A8 < B8+CIN (unsigned).
- R8/COUT hold their value until the next completion or reset.

## Timing
- START is sampled at edge 0. State is LO in cycle 1, HI in cycle 2, FIN in cycle 3. DONE=1 and R8 valid in cycle 4.
- Latency: 4 cycles from acceptance to DONE.
- DONE is high for exactly one cycle; the FSM is in IDLE during that cycle. A START in the DONE cycle is accepted, giving a throughput of one operation per 4 cycles.
- START while BUSY=1 is ignored; there is no queueing. Operands may change freely after the acceptance edge.
- Reset (RST=1 at an edge, from any state, including mid-operation):
  - Next cycle: IDLE, BUSY=0, DONE=0, R8=0x00, COUT=0; no DONE for the aborted operation.
  - While RST=1: MODO=11, ENB=1, A=B=0, RCI=0 (combinational on RST), so the unit's Q and RCO clear at the same edge.

## Configuration
- ALU8_STATUS_EN defined: adds output ports ZERO (1 bit) and OVF (1 bit). Both are registered alongside R8 at the FIN exit edge and reset to 0.
  - ZERO = (R8 == 0).
  - OVF = signed two's-complement overflow of the 8-bit operation; always 0 for clear.
- ALU8_STATUS_EN undefined: ports ZERO and OVF and their logic are absent; all other behaviour is identical.

## Test plan
- RST high for 2 cycles after power-up → R8=0x00, COUT=0, BUSY=0, DONE=0, unit Q=0000.
- Add A8=0x7F, B8=0x01, CIN=0 → DONE exactly 4 cycles after acceptance, R8=0x80, COUT=0; OVF=1 and ZERO=0 when ALU8_STATUS_EN is defined.
- Add A8=0xFF, B8=0x01, CIN=1 → R8=0x01, COUT=1 (low-nibble carry propagates). Clear afterwards → R8=0x00, COUT=0, ZERO=1.
- Subtract 0x10−0x01, CIN=0 → R8=0x0F, COUT=0 (borrow chained). Subtract 0x01−0x04, CIN=1 → R8=0xFC, COUT=1.
- START held high with new operands during BUSY → ignored, single DONE. START with OP=00 → no BUSY, no DONE. START in the DONE cycle → accepted, second DONE 4 cycles later.
- RST asserted while in HI → next cycle IDLE, BUSY=0, R8=0x00, no DONE pulse. A new add 0x22+0x11 then completes with R8=0x33.

Source files
------------

// File: rtl/alu8_sequencer.sv
// ---------------------------------------------------------------------------
// alu8_sequencer : 8-bit add/sub/clear sequenced over a 4-bit registered unit.
// Optional status outputs ZERO/OVF enabled by defining ALU8_STATUS_EN.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module alu8_sequencer (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic [1:0] OP,
  input  logic [7:0] A8,
  input  logic [7:0] B8,
  input  logic       CIN,
  output logic       BUSY,
  output logic       DONE,
  output logic [7:0] R8,
  output logic       COUT,
`ifdef ALU8_STATUS_EN
  output logic       ZERO,
  output logic       OVF,
`endif
  output logic [3:0] A,
  output logic [3:0] B,
  output logic [1:0] MODO,
  output logic       ENB,
  output logic       RCI,
  input  logic [3:0] Q,
  input  logic       RCO
);

  localparam logic [1:0] C_OP_ADD = 2'b01;
  localparam logic [1:0] C_OP_SUB = 2'b10;
  localparam logic [1:0] C_OP_CLR = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LO   = 2'd1,
    S_HI   = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  state_t     r_state;
  logic [7:0] r_a;
  logic [7:0] r_b;
  logic       r_cin;
  logic [1:0] r_op;

`ifdef ALU8_STATUS_EN
  // Sign of the result is the high nibble's top bit, available from Q at FIN exit.
  logic w_ovf;
  always_comb begin
    w_ovf = 1'b0;
    if (r_op == C_OP_ADD)
      w_ovf = (r_a[7] == r_b[7]) && (Q[3] != r_a[7]);
    else if (r_op == C_OP_SUB)
      w_ovf = (r_a[7] != r_b[7]) && (Q[3] != r_a[7]);
  end
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_a     <= 8'h00;
      r_b     <= 8'h00;
      r_cin   <= 1'b0;
      r_op    <= 2'b00;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      R8      <= 8'h00;
      COUT    <= 1'b0;
`ifdef ALU8_STATUS_EN
      ZERO    <= 1'b0;
      OVF     <= 1'b0;
`endif
    end else begin
      DONE <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (START && (OP != 2'b00)) begin
            r_a     <= A8;
            r_b     <= B8;
            r_cin   <= CIN;
            r_op    <= OP;
            BUSY    <= 1'b1;
            r_state <= S_LO;
          end
        end
        S_LO: r_state <= S_HI;
        S_HI: begin
          R8[3:0] <= Q;
          r_state <= S_FIN;
        end
        S_FIN: begin
          R8[7:4] <= Q;
          COUT    <= RCO;
          DONE    <= 1'b1;
          BUSY    <= 1'b0;
          r_state <= S_IDLE;
`ifdef ALU8_STATUS_EN
          ZERO    <= ({Q, R8[3:0]} == 8'h00);
          OVF     <= w_ovf;
`endif
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Unit drive is decoded from state; reset forces a clear so the unit's Q/RCO
  // are zeroed on the same edge as this controller.
  always_comb begin
    A    = 4'h0;
    B    = 4'h0;
    MODO = 2'b00;
    ENB  = 1'b0;
    RCI  = 1'b0;
    if (RST) begin
      MODO = C_OP_CLR;
      ENB  = 1'b1;
    end else begin
      case (r_state)
        S_LO: begin
          A    = r_a[3:0];
          B    = r_b[3:0];
          MODO = r_op;
          ENB  = 1'b1;
          RCI  = r_cin;
        end
        S_HI: begin
          A    = r_a[7:4];
          B    = r_b[7:4];
          MODO = r_op;
          ENB  = 1'b1;
          RCI  = RCO;
        end
        default: ;
      endcase
    end
  end

  // C_OP_SUB is referenced only by the status logic; keep it used in all builds.
  logic w_unused;
  assign w_unused = ^C_OP_SUB;

endmodule

`default_nettype wire

// File: tb/tb_alu8_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu8_sequencer : directed self-checking bench with a behavioural 4-bit unit.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_alu8_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] op;
  logic [7:0] a8, b8;
  logic       cin;
  logic       busy, done, cout;
  logic [7:0] r8;
  logic [3:0] ua, ub, uq;
  logic [1:0] modo;
  logic       enb, rci, urco;
`ifdef ALU8_STATUS_EN
  logic       zero, ovf;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu8_sequencer dut (
    .CLK(clk), .RST(rst), .START(start), .OP(op), .A8(a8), .B8(b8), .CIN(cin),
    .BUSY(busy), .DONE(done), .R8(r8), .COUT(cout),
`ifdef ALU8_STATUS_EN
    .ZERO(zero), .OVF(ovf),
`endif
    .A(ua), .B(ub), .MODO(modo), .ENB(enb), .RCI(rci), .Q(uq), .RCO(urco)
  );

  // Behavioural model of the 4-bit registered add/subtract unit
  function automatic logic [4:0] unit_next(input logic [1:0] m, input logic [3:0] x,
                                           input logic [3:0] y, input logic ci);
    logic [4:0] t;
    case (m)
      2'b01:   t = {1'b0, x} + {1'b0, y} + {4'b0, ci};
      2'b10:   t = {1'b0, x} - {1'b0, y} - {4'b0, ci};
      default: t = 5'b0;
    endcase
    return t;
  endfunction

  always @(posedge clk) begin
    if (enb && modo != 2'b00) {urco, uq} <= unit_next(modo, ua, ub, rci);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                          input logic c);
    start = 1'b1; op = o; a8 = x; b8 = y; cin = c;
    tick();
    start = 1'b0;
  endtask

  // Called in cycle 1 after acceptance; returns in the DONE cycle (or on timeout).
  task automatic wait_done(input string tag, input logic [7:0] er, input logic ec);
    int n;
    n = 1;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    while (done !== 1'b1 && n < 12) begin
      tick();
      n++;
    end
    check({tag, "_lat"}, 32'(n), 32'd4);
    check({tag, "_r8"}, 32'(r8), 32'(er));
    check({tag, "_cout"}, 32'(cout), 32'(ec));
  endtask

  task automatic no_done(input string tag, input int cycles);
    int pulses;
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (done === 1'b1) pulses++;
    end
    check({tag, "_nodone"}, 32'(pulses), 32'd0);
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 2'b00; a8 = 8'h00; b8 = 8'h00; cin = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_r8", 32'(r8), 32'h00);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_q", 32'(uq), 32'h0);
`ifdef ALU8_STATUS_EN
    check("rst_zero", 32'(zero), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
`endif

    start_op(2'b01, 8'h7F, 8'h01, 1'b0);
    wait_done("add7f01", 8'h80, 1'b0);
`ifdef ALU8_STATUS_EN
    check("add7f01_ovf", 32'(ovf), 32'd1);
    check("add7f01_zero", 32'(zero), 32'd0);
`endif

    start_op(2'b01, 8'hFF, 8'h01, 1'b1);
    wait_done("addff01c", 8'h01, 1'b1);

    start_op(2'b11, 8'hA5, 8'h5A, 1'b1);
    wait_done("clr", 8'h00, 1'b0);
`ifdef ALU8_STATUS_EN
    check("clr_zero", 32'(zero), 32'd1);
    check("clr_ovf", 32'(ovf), 32'd0);
`endif

    start_op(2'b10, 8'h10, 8'h01, 1'b0);
    wait_done("sub1001", 8'h0F, 1'b0);

    start_op(2'b10, 8'h01, 8'h04, 1'b1);
    wait_done("sub0104b", 8'hFC, 1'b1);

    // START held high with changing operands while busy: only the first is run
    start = 1'b1; op = 2'b01; a8 = 8'h05; b8 = 8'h03; cin = 1'b0;
    tick();
    a8 = 8'h40; b8 = 8'h40;
    tick();
    tick();
    tick();
    check("hold_done", 32'(done), 32'd1);
    check("hold_r8", 32'(r8), 32'h08);
    start = 1'b0;
    no_done("hold", 6);

    // Illegal OP=00 is ignored
    start = 1'b1; op = 2'b00; a8 = 8'h12; b8 = 8'h34;
    tick();
    start = 1'b0;
    check("op00_busy", 32'(busy), 32'd0);
    no_done("op00", 6);

    // Back-to-back: new START issued in the DONE cycle
    start_op(2'b01, 8'h11, 8'h22, 1'b0);
    wait_done("b2b1", 8'h33, 1'b0);
    start_op(2'b10, 8'h50, 8'h20, 1'b0);
    wait_done("b2b2", 8'h30, 1'b0);

    // Reset during the HI pass aborts without a DONE
    start_op(2'b01, 8'h99, 8'h11, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_r8", 32'(r8), 32'h00);
    check("abort_cout", 32'(cout), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_q", 32'(uq), 32'h0);
    rst = 1'b0;
    no_done("abort", 6);

    start_op(2'b01, 8'h22, 8'h11, 1'b0);
    wait_done("post_abort", 8'h33, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
